// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory write buffer
// Purpose: buffered-store entry layout and the word offset of byte addresses.
package dmem_pkg;

  // One buffered store: word address (byte address >> WORD_OFFSET) and data.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/wbuf_fwd_select.sv
// rtl/wbuf_fwd_select.sv - youngest-match store-to-load forwarding selector
// Purpose: scan the buffered stores and return the data of the youngest entry
//          whose word address equals the lookup address.
// Ports:
//   entries_i  in   buffered stores, indexed by FIFO slot
//   valid_i    in   per-slot valid mask
//   head_i     in   slot of the oldest entry
//   lookup_i   in   word address of the load
//   hit_o      out  at least one valid entry matches
//   data_o     out  data of the youngest matching entry (0 when no hit)
module wbuf_fwd_select
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  wbuf_entry_t             entries_i [DEPTH],
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [AW-1:0]           lookup_i,
  output logic                    hit_o,
  output logic [31:0]             data_o
);

  localparam int PW = $clog2(DEPTH);

  // Walk slots from oldest to youngest so a later match overrides an earlier
  // one; the last assignment made is therefore the youngest match.
  always_comb begin
    logic [PW-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && (entries_i[idx].addr[AW-1:0] == lookup_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - CPU data-port store buffer with load forwarding
// Purpose: queue CPU stores in a small FIFO, drain them to the RAM through a
//          valid/ready write handshake in program order, and serve loads from
//          the RAM overridden by the youngest matching buffered store.
// Ports:
//   sys_clk, sys_rst_n        clock (rising edge), async active-low reset
//   daddr, din, MemWrite      CPU data address, store data, store request
//   dout, stall               load data to CPU, store-not-accepted hold
//   mem_raddr, mem_rdata      RAM combinational read port
//   mem_waddr, mem_wdata      RAM write address/data from the FIFO head
//   mem_we, mem_ready         write valid / RAM accepts write
//   count                     FIFO occupancy
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [31:0]              daddr,
  input  logic [31:0]              din,
  input  logic                     MemWrite,
  output logic [31:0]              dout,
  output logic                     stall,
  output logic [31:0]              mem_raddr,
  input  logic [31:0]              mem_rdata,
  output logic [31:0]              mem_waddr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t      entries_q [DEPTH];
  wbuf_entry_t      entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty, push, pop;
  logic fwd_hit;
  logic [31:0] fwd_data;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // stall depends only on registered occupancy: a full buffer refuses the
  // store even when the head drains on the same edge.
  assign push  = MemWrite && !full;
  assign stall = MemWrite && full;
  assign pop   = mem_we && mem_ready;

  assign mem_we    = !empty;
  assign mem_waddr = mem_we ? {entries_q[head_q].addr, {WORD_OFFSET{1'b0}}} : '0;
  assign mem_wdata = mem_we ? entries_q[head_q].data : '0;
  assign mem_raddr = daddr;
  assign count     = count_q;

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    // Pop and push never address the same slot: that would need the FIFO to be
    // both empty (pop blocked) and full (push blocked).
    if (pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      entries_d[tail_q] = '{addr: daddr[31:WORD_OFFSET], data: din};
      valid_d[tail_q]   = 1'b1;
    end
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Only registered entries are searched, so a store pushed this cycle is not
  // forwarded while a popping head entry still is.
  wbuf_fwd_select #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .head_i    (head_q),
    .lookup_i  (daddr[AW+WORD_OFFSET-1:WORD_OFFSET]),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign dout = fwd_hit ? fwd_data : mem_rdata;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - directed self-checking bench for dmem_write_buffer
module tb_dmem_write_buffer;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [31:0] daddr;
  logic [31:0] din;
  logic        MemWrite;
  logic [31:0] dout;
  logic        stall;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic [2:0]  count;

  int checks;
  int errors;

  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  int          log_n;

  dmem_write_buffer #(.DEPTH(4), .AW(30)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .daddr     (daddr),
    .din       (din),
    .MemWrite  (MemWrite),
    .dout      (dout),
    .stall     (stall),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .count     (count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Handshake inputs are stable across the cycle, so the negedge sees exactly
  // the write that the following rising edge will retire.
  always @(negedge sys_clk) begin
    if (sys_rst_n && mem_we && mem_ready && log_n < 64) begin
      log_addr[log_n] = mem_waddr;
      log_data[log_n] = mem_wdata;
      log_n = log_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int base;
    checks    = 0;
    errors    = 0;
    log_n     = 0;
    sys_rst_n = 1'b0;
    daddr     = 32'h0;
    din       = 32'h0;
    MemWrite  = 1'b0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;

    // Reset and idle load
    #1;
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    #12 sys_rst_n = 1'b1;
    tick();
    daddr = 32'h10; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_dout", dout, 32'hDEAD_BEEF);
    chk("idle_raddr", mem_raddr, 32'h10);

    // Single store held for three not-ready cycles, then drained
    daddr = 32'h20; din = 32'h1111_1111; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("single_we", {31'b0, mem_we}, 32'd1);
      chk("single_waddr", mem_waddr, 32'h20);
      chk("single_wdata", mem_wdata, 32'h1111_1111);
      chk("single_count", {29'b0, count}, 32'd1);
      tick();
    end
    mem_ready = 1'b1;
    chk("single_waddr_rdy", mem_waddr, 32'h20);
    tick();
    mem_ready = 1'b0;
    chk("single_count_after", {29'b0, count}, 32'd0);
    chk("single_we_after", {31'b0, mem_we}, 32'd0);
    chk("single_log_n", log_n, 32'd1);
    chk("single_log_addr", log_addr[0], 32'h20);
    chk("single_log_data", log_data[0], 32'h1111_1111);

    // Forwarding: youngest match wins, same-cycle push is not forwarded
    MemWrite = 1'b1;
    daddr = 32'h40; din = 32'hA; tick();
    daddr = 32'h40; din = 32'hB; tick();
    daddr = 32'h44; din = 32'hC; tick();
    MemWrite = 1'b0; mem_rdata = 32'h5555_5555;
    daddr = 32'h40; #1; chk("fwd_40", dout, 32'hB);
    daddr = 32'h44; #1; chk("fwd_44", dout, 32'hC);
    daddr = 32'h48; #1; chk("fwd_48_miss", dout, 32'h5555_5555);
    daddr = 32'h43; #1; chk("fwd_low_bits", dout, 32'hB);
    daddr = 32'h48; din = 32'hD; MemWrite = 1'b1; #1;
    chk("fwd_same_cycle", dout, 32'h5555_5555);
    chk("fwd_count3", {29'b0, count}, 32'd3);
    tick();
    MemWrite = 1'b0;
    chk("fwd_after_push", dout, 32'hD);
    chk("fwd_count4", {29'b0, count}, 32'd4);
    daddr = 32'h40; mem_ready = 1'b1; #1;
    chk("fwd_while_pop", dout, 32'hB);
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b0;
    chk("fwd_drain_count", {29'b0, count}, 32'd0);
    chk("fwd_log_n", log_n, 32'd5);
    chk("fwd_log1_a", log_addr[1], 32'h40); chk("fwd_log1_d", log_data[1], 32'hA);
    chk("fwd_log2_a", log_addr[2], 32'h40); chk("fwd_log2_d", log_data[2], 32'hB);
    chk("fwd_log3_a", log_addr[3], 32'h44); chk("fwd_log3_d", log_data[3], 32'hC);
    chk("fwd_log4_a", log_addr[4], 32'h48); chk("fwd_log4_d", log_data[4], 32'hD);

    // Full buffer stalls even while it pops
    MemWrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      daddr = 32'h100 + 32'(4 * i); din = 32'h100 + 32'(i);
      tick();
    end
    daddr = 32'h200; din = 32'h55; #1;
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("full_count_hold", {29'b0, count}, 32'd4);
    mem_ready = 1'b1; #1;
    chk("full_stall_with_ready", {31'b0, stall}, 32'd1);
    tick();
    mem_ready = 1'b0;
    chk("full_after_pop_count", {29'b0, count}, 32'd3);
    chk("full_after_pop_stall", {31'b0, stall}, 32'd0);
    tick();
    MemWrite = 1'b0;
    chk("full_fifth_accepted", {29'b0, count}, 32'd4);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b0;
    chk("full_drain_count", {29'b0, count}, 32'd0);
    chk("full_log_n", log_n, 32'd10);
    for (int i = 0; i < 4; i++) begin
      chk("full_log_a", log_addr[5 + i], 32'h100 + 32'(4 * i));
      chk("full_log_d", log_data[5 + i], 32'h100 + 32'(i));
    end
    chk("full_log_a5", log_addr[9], 32'h200);
    chk("full_log_d5", log_data[9], 32'h55);

    // Steady push+pop at occupancy 2, pointers wrap several times
    base = log_n;
    MemWrite = 1'b1;
    for (int i = 0; i < 12; i++) begin
      daddr = 32'h300 + 32'(4 * i); din = 32'h3000 + 32'(i);
      if (i == 2) mem_ready = 1'b1;
      if (i >= 2) chk("pp_count", {29'b0, count}, 32'd2);
      tick();
    end
    MemWrite = 1'b0;
    chk("pp_count_end", {29'b0, count}, 32'd2);
    tick(); tick();
    mem_ready = 1'b0;
    chk("pp_drain_count", {29'b0, count}, 32'd0);
    chk("pp_log_n", log_n - base, 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("pp_log_a", log_addr[base + i], 32'h300 + 32'(4 * i));
      chk("pp_log_d", log_data[base + i], 32'h3000 + 32'(i));
    end

    // Asynchronous reset in the middle of a drain discards pending stores
    MemWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      daddr = 32'h500 + 32'(4 * i); din = 32'h5000 + 32'(i);
      tick();
    end
    MemWrite = 1'b0;
    chk("mid_count_pre", {29'b0, count}, 32'd3);
    base = log_n;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_we", {31'b0, mem_we}, 32'd0);
    chk("mid_count", {29'b0, count}, 32'd0);
    chk("mid_waddr", mem_waddr, 32'd0);
    mem_ready = 1'b1;
    #3 sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_no_stale_we", {31'b0, mem_we}, 32'd0);
    chk("mid_no_stale_log", log_n - base, 32'd0);
    daddr = 32'h500; mem_rdata = 32'h7777_7777; #1;
    chk("mid_no_stale_fwd", dout, 32'h7777_7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Sits directly downstream of the single-cycle CPU's data port (daddr/din/MemWrite/dout), between the CPU and the data RAM.
- Accepts CPU stores into a small FIFO and drains them to the RAM through a ready/valid write handshake, so a slow RAM write path does not stall every store.
- Serves CPU loads combinationally from the RAM, overridden by the youngest matching buffered store (store-to-load forwarding).

Parameters:
DEPTH, 4, number of buffered stores; power of two, at least 2
AW, 30, word-address width compared for forwarding (addresses daddr[31:2])

Ports:
sys_clk  in  1  clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
daddr  in  32  CPU data byte address; word-aligned, bits [1:0] ignored
din  in  32  CPU store data
MemWrite  in  1  CPU store request this cycle
dout  out  32  load data to CPU (combinational)
stall  out  1  CPU must hold the current instruction; the store is not accepted
mem_raddr  out  32  RAM read address, equal to daddr
mem_rdata  in  32  RAM read data (combinational RAM read)
mem_waddr  out  32  RAM write address, taken from the FIFO head
mem_wdata  out  32  RAM write data, taken from the FIFO head
mem_we  out  1  write valid; high whenever the FIFO is non-empty
mem_ready  in  1  RAM accepts the write this cycle
count  out  $clog2(DEPTH)+1  current occupancy, for debug and performance counters

Behaviour:
- Reset (asynchronous, sys_rst_n=0): head=tail=count=0 and all entry valid bits cleared. Outputs: mem_we=0, stall=0, mem_waddr=0, mem_wdata=0. Stores still pending when reset asserts are discarded, even mid-drain.
- State: DEPTH entries {addr[31:2], data[31:0]}, head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register. full = (count==DEPTH); empty = (count==0).
- Push: on a clock edge when MemWrite && !full, write {daddr[31:2], din} at tail and advance tail by 1. Latency is 1 cycle: the entry is visible for forwarding and draining in the next cycle.
- stall = MemWrite && full, purely from registered state. There is no path from mem_ready to stall: a full buffer stalls for the cycle even if it pops that same cycle.
- Drain: mem_we = !empty; mem_waddr = {head.addr, 2'b00}; mem_wdata = head.data. Pop on the edge where mem_we && mem_ready, advancing head by 1. The head entry must stay stable while mem_we && !mem_ready.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Count update: count_next = count + push - pop. It never exceeds DEPTH and never goes below 0.
- Forwarding: compare daddr[31:2] against every valid entry.
  - If one or more entries match, dout = data of the youngest match, i.e. the closest to tail in FIFO order.
  - Otherwise dout = mem_rdata.
  - A store being pushed this same cycle is not forwarded.
  - An entry popping this cycle still forwards this cycle.
- No store coalescing: duplicate addresses occupy separate entries and drain in program order.
- Ordering guarantee: the RAM sees writes in exactly the CPU's store order, one per handshake.

Decomposition:
- Package dmem_pkg holds:
  - typedef wbuf_entry_t {logic [29:0] addr; logic [31:0] data;}
  - the localparam WORD_OFFSET = 2
- Sub-module wbuf_fwd_select: a combinational youngest-match priority selector over DEPTH entries. Inputs are entries, valid mask, head and lookup address; outputs are hit and data. It is instantiated once.
- The FIFO pointers and count live in the top module.

Test Plan:
- Reset then idle: after sys_rst_n rises, mem_we=0, stall=0, count=0. A load from daddr=0x10 with mem_rdata=0xDEAD_BEEF gives dout=0xDEAD_BEEF.
- Single store and drain: store 0x1111_1111 to 0x20 with mem_ready=0 for 3 cycles, then 1.
  - mem_we=1 with waddr=0x20 and wdata=0x1111_1111 held stable for 3 cycles.
  - Pop on the 4th edge, after which count=0.
- Forwarding: stores to 0x40 with data A=0xA, then 0x40 with B=0xB, then 0x44 with C=0xC, all with mem_ready=0.
  - Loading 0x40 gives dout=0xB.
  - Loading 0x44 gives dout=0xC.
  - Loading 0x48 gives dout=mem_rdata.
- Full/stall: with mem_ready=0, push DEPTH=4 stores; the 5th store sees stall=1 and count stays 4. Raise mem_ready for one cycle: the head pops, stall drops next cycle, and the 5th store is accepted.
- Simultaneous push/pop with wrap: keep count=2 while pushing and popping every cycle for 10 cycles. count stays 2, the pointers wrap past 3→0, and the RAM write sequence equals the store sequence exactly.
- Reset mid-drain: 3 stores pending with mem_ready=0, then assert sys_rst_n=0 asynchronously mid-cycle. mem_we drops immediately and count=0; after release, no stale write reaches the RAM.
